// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencing controller for an iterative RV64 M-extension unit.
// Accepts one operation per handshake, iterates a radix-2 shift-add multiply
// or a restoring divide, then holds the result until the pipeline takes it.
// Special cases (divide by zero, signed overflow, illegal W multiply-high)
// can finish with no iteration when FAST_SPECIAL is set.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   flush          abort in-flight or pending operation
//   in_valid/ready request handshake; in_op, in_word, in_a, in_b operands
//   out_valid/ready result handshake; out_result final value
//   busy           stall indication for the front of the pipeline
module muldiv_sched #(
   parameter int XLEN         = 64,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            busy
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // Latched control of the operation in flight.
   typedef struct packed {
      logic [2:0] op;
      logic       word;
      logic       a_neg;   // |a| was taken; fix the sign at the end
      logic       b_neg;
      logic       special; // result comes from spec_q, not the iteration
   } ctl_t;

   state_t        state, state_nx;
   ctl_t          ctl;
   logic [127:0]  acc;     // mul: {product hi, multiplier}; div: {remainder, dividend/quotient}
   logic [63:0]   opb;     // multiplicand or divisor magnitude
   logic [63:0]   spec_q;
   logic [6:0]    cnt;

   // ---------------- request decode (IDLE, combinational) ----------------
   logic          is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic          illegal, b_zero, ovf, special, last;
   logic [63:0]   a_ext, b_ext, a_abs, b_abs, a_sx, min_v, spec_res, lo_init;

   always_comb begin
      is_div  = in_op[2];
      a_sgn   = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                (in_op == OP_DIV)  || (in_op == OP_REM);
      b_sgn   = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
      a_ext   = in_word ? {{32{a_sgn & in_a[31]}}, in_a[31:0]} : in_a;
      b_ext   = in_word ? {{32{b_sgn & in_b[31]}}, in_b[31:0]} : in_b;
      a_neg   = a_sgn & a_ext[63];
      b_neg   = b_sgn & b_ext[63];
      a_abs   = a_neg ? (~a_ext + 64'd1) : a_ext;
      b_abs   = b_neg ? (~b_ext + 64'd1) : b_ext;
      // W remainder-by-zero returns sext(a[31:0]) whatever the signedness
      a_sx    = in_word ? {{32{in_a[31]}}, in_a[31:0]} : in_a;
      min_v   = in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      illegal = in_word & ~is_div & (in_op != OP_MUL);
      b_zero  = is_div & (b_ext == 64'd0);
      ovf     = is_div & b_sgn & (a_ext == min_v) & (b_ext == '1);
      special = illegal | b_zero | ovf;
      spec_res = 64'd0;
      if (illegal)     spec_res = 64'd0;
      else if (b_zero) spec_res = in_op[1] ? a_sx : '1;
      else if (ovf)    spec_res = in_op[1] ? 64'd0 : min_v;
      // A W divide only walks 32 dividend bits, so start them at the top.
      lo_init = (is_div && in_word) ? {a_abs[31:0], 32'd0} : a_abs;
   end

   // ---------------- one iteration ----------------
   logic [64:0]   mul_sum;
   logic [64:0]   rem_sh;
   logic          fits;
   logic [63:0]   rem_nx;
   logic [127:0]  acc_nx;
   logic [63:0]   fin_res;

   function automatic logic [63:0] finish_res(input logic [127:0] p, input ctl_t c);
      logic         neg;
      logic [127:0] pn;
      logic [63:0]  q, r, d;
      neg = c.a_neg ^ c.b_neg;
      pn  = neg ? (~p + 128'd1) : p;
      q   = neg ? (~p[63:0] + 64'd1) : p[63:0];
      r   = c.a_neg ? (~p[127:64] + 64'd1) : p[127:64];
      case (c.op)
         OP_MUL:            d = c.word ? {{32{p[63]}}, p[63:32]} : p[63:0];
         OP_MULH,
         OP_MULHSU:         d = pn[127:64];
         OP_MULHU:          d = p[127:64];
         OP_DIV, OP_DIVU:   d = c.word ? {{32{q[31]}}, q[31:0]} : q;
         default:           d = c.word ? {{32{r[31]}}, r[31:0]} : r;
      endcase
      return d;
   endfunction

   always_comb begin
      mul_sum = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opb} : 65'd0);
      rem_sh  = {acc[127:64], acc[63]};
      fits    = rem_sh >= {1'b0, opb};
      // When the trial fits the true difference is below 2^64, so 64-bit
      // wraparound arithmetic is exact; otherwise rem_sh[64] is 0.
      rem_nx  = fits ? (rem_sh[63:0] - opb) : rem_sh[63:0];
      acc_nx  = ctl.op[2] ? {rem_nx, acc[62:0], fits} : {mul_sum, acc[63:1]};
      fin_res = finish_res(acc_nx, ctl);
      last    = (cnt <= 7'd1);
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) state_nx = S_IDLE;
      else begin
         case (state)
            S_IDLE: if (in_valid) state_nx = (special && FAST_SPECIAL) ? S_DONE : S_BUSY;
            S_BUSY: if (last)      state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default:               state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      busy      = (state == S_BUSY) || ((state == S_DONE) && !out_ready);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         opb        <= '0;
         ctl        <= '0;
         spec_q     <= '0;
         cnt        <= '0;
         out_result <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               ctl    <= '{op: in_op, word: in_word, a_neg: a_neg, b_neg: b_neg, special: special};
               acc    <= {64'd0, lo_init};
               opb    <= b_abs;
               spec_q <= spec_res;
               if (special && FAST_SPECIAL) begin
                  cnt        <= '0;
                  out_result <= spec_res;
               end else begin
                  cnt <= in_word ? 7'd32 : 7'd64;
               end
            end
            S_BUSY: begin
               acc <= acc_nx;
               cnt <= cnt - 7'd1;
               // final iteration and sign fix-up share the edge into DONE
               if (last) out_result <= ctl.special ? spec_q : fin_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic        in_word = 1'b0;
   logic [63:0] in_a = 64'd0;
   logic [63:0] in_b = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   muldiv_sched #(.XLEN(64), .FAST_SPECIAL(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 24;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called #1 after a posedge with the DUT idle. lat counts the accept
   // cycle as cycle 0 and returns the cycle index where out_valid is seen.
   task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
      int n;
      in_op = op; in_word = w; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         lat++; n++;
      end
      res = out_result;
      if (!out_valid) lat = -1;
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] res, held;
      int          lat;
      logic        saw;

      vec[0]  = '{"mul",        3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
      vec[1]  = '{"mulhu",      3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_0006, 65};
      vec[2]  = '{"div",        3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      vec[3]  = '{"rem",        3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      vec[4]  = '{"divuw",      3'd5, 1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 33};
      vec[5]  = '{"divu_by0",   3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vec[6]  = '{"rem_by0",    3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
      vec[7]  = '{"div_ovf",    3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1};
      vec[8]  = '{"remw_ovf",   3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      vec[9]  = '{"divw_ovf",   3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1};
      vec[10] = '{"mulhw_ill",  3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 1};
      vec[11] = '{"divw_by0",   3'd4, 1'b1, 64'd9, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vec[12] = '{"remuw_by0",  3'd7, 1'b1, 64'h8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
      vec[13] = '{"mulh_neg",   3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65};
      vec[14] = '{"mulhsu",     3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
      vec[15] = '{"mulh_min",   3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  64'h4000_0000_0000_0000, 65};
      vec[16] = '{"mulhu_max",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, 65};
      vec[17] = '{"mulw_wrap",  3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33};
      vec[18] = '{"mulw_sext",  3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
      vec[19] = '{"divw_neg",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
      vec[20] = '{"remw_neg",   3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      vec[21] = '{"remuw",      3'd7, 1'b1, 64'h1_0000_0011, 64'd4, 64'd1, 33};
      vec[22] = '{"div_negb",   3'd4, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      vec[23] = '{"rem_nega",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};

      // reset state, observed before any clock edge
      #2;
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy",      {63'd0, busy},      64'd0);
      chk("rst_result",    out_result,         64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         do_op(vec[i].op, vec[i].word, vec[i].a, vec[i].b, res, lat);
         chk({vec[i].name, "_res"}, res, vec[i].exp);
         chk({vec[i].name, "_lat"}, 64'(lat), 64'(vec[i].lat));
         take();
      end

      // backpressure: result held, competing request refused
      do_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, held, lat);
      in_op = 3'd0; in_word = 1'b0; in_a = 64'd3; in_b = 64'd4; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_valid",    {63'd0, out_valid}, 64'd1);
         chk("bp_result",   out_result,         64'hFFFF_FFFF_FFFF_FFEB);
         chk("bp_busy",     {63'd0, busy},      64'd1);
         chk("bp_in_ready", {63'd0, in_ready},  64'd0);
      end
      out_ready = 1'b1;
      #1 chk("bp_busy_on_take", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("bp_idle_ready", {63'd0, in_ready},  64'd1);
      chk("bp_idle_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_not_taken",  {63'd0, busy},      64'd0);
      do_op(3'd5, 1'b0, 64'd100, 64'd7, res, lat);
      chk("bp_next_res", res, 64'd14);
      chk("bp_next_lat", 64'(lat), 64'd65);
      take();

      // flush together with a request in IDLE drops it
      in_op = 3'd0; in_a = 64'd9; in_b = 64'd9; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_idle_ready", {63'd0, in_ready}, 64'd1);
      chk("fl_idle_busy",  {63'd0, busy},     64'd0);

      // flush at BUSY cycle 20
      in_op = 3'd4; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("fl_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
      chk("fl_busy",     {63'd0, busy},     64'd0);
      saw = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("fl_no_valid", {63'd0, saw}, 64'd0);
      do_op(3'd0, 1'b0, 64'd3, 64'd4, res, lat);
      chk("fl_mul_res", res, 64'd12);
      chk("fl_mul_lat", 64'(lat), 64'd65);
      take();

      // asynchronous reset mid-BUSY
      in_op = 3'd0; in_word = 1'b0; in_a = 64'd7; in_b = 64'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("ar_in_ready",  {63'd0, in_ready},  64'd1);
      chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_busy",      {63'd0, busy},      64'd0);
      chk("ar_result",    out_result,         64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      do_op(3'd4, 1'b0, 64'd100, 64'd7, res, lat);
      chk("ar_div_res", res, 64'd14);
      chk("ar_div_lat", 64'(lat), 64'd65);
      take();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
